// File: rtl/lvds_pll_pkg.sv
// rtl/lvds_pll_pkg.sv - shared types, reset defaults and width helper for the LVDS PLL controller
// Contents: state_e (controller states), *_INIT_DEF (dynamic-adjust reset values),
//           cnt_width() (counter width able to hold the largest timing parameter).
package lvds_pll_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    FILTER,
    READY,
    SETTLE
  } state_e;

  localparam logic [3:0] PSDA_INIT_DEF = 4'b0000;
  localparam logic [3:0] DUTY_INIT_DEF = 4'b1000;
  localparam logic [3:0] FDLY_INIT_DEF = 4'b0000;

  // Bits needed to hold the largest of the four timing parameters as a count value.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lvds_sync2.sv
// rtl/lvds_sync2.sv - two-flop synchronizer, clears to 0 on reset
// Ports: clk_i (destination clock), rst_ni (async active-low reset),
//        d_i (asynchronous input), q_o (synchronized output).
module lvds_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lvds_pll_ctrl.sv
// rtl/lvds_pll_ctrl.sv - LVDS TX rPLL sequencer: reset, lock filtering, recovery, dynamic adjust
// Ports: clk/rst_n (control clock, async active-low reset); pll_reset, pll_lock (PLL reset/lock);
//        psda/dutyda/fdly (dynamic adjust to PLL); cfg_req/cfg_psda/cfg_duty/cfg_fdly/cfg_ack/cfg_busy
//        (four-phase change request); relock_req (forced re-reset); clk_ready, lock_loss_cnt,
//        timeout_err (status).
module lvds_pll_ctrl
  import lvds_pll_pkg::*;
#(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_FILT     = 8,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         LOCK_TIMEOUT  = 65535,
  parameter logic [3:0] PSDA_INIT     = PSDA_INIT_DEF,
  parameter logic [3:0] DUTY_INIT     = DUTY_INIT_DEF,
  parameter logic [3:0] FDLY_INIT     = FDLY_INIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pll_reset,
  input  logic       pll_lock,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic [3:0] fdly,
  input  logic       cfg_req,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_duty,
  input  logic [3:0] cfg_fdly,
  output logic       cfg_ack,
  output logic       cfg_busy,
  input  logic       relock_req,
  output logic       clk_ready,
  output logic [7:0] lock_loss_cnt,
  output logic       timeout_err
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_FILT, SETTLE_CYCLES, LOCK_TIMEOUT);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   to_q, to_d;
  logic [7:0]      loss_q, loss_d;
  logic            tout_q, tout_d;
  logic            pend_q, pend_d;
  logic            arm_q, arm_d;
  logic            ack_d;
  logic [3:0]      psda_q, psda_d, duty_q, duty_d, fdly_q, fdly_d;
  logic            pll_reset_q, clk_ready_q, cfg_ack_q;
  logic            lock_s;

  lvds_sync2 u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    to_d    = to_q;
    loss_d  = loss_q;
    tout_d  = tout_q;
    pend_d  = pend_q;
    // A request only re-arms once cfg_req has been seen low, so a held request is taken once.
    arm_d   = arm_q | ~cfg_req;
    psda_d  = psda_q;
    duty_d  = duty_q;
    fdly_d  = fdly_q;
    ack_d   = 1'b0;

    case (state_q)
      RESET_HOLD: begin
        to_d = '0;
        if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      WAIT_LOCK: begin
        to_d = to_q + CW'(1);
        if (lock_s) begin
          // The detecting cycle already counts as the first filtered lock cycle.
          state_d = (LOCK_FILT <= 1) ? READY : FILTER;
          cnt_d   = CW'(1);
        end else if (to_d == CW'(LOCK_TIMEOUT)) begin
          tout_d  = 1'b1;
          state_d = RESET_HOLD;
        end
      end
      FILTER: begin
        // Timeout counter is deliberately kept so repeated glitches still time out.
        if (!lock_s)                                 state_d = WAIT_LOCK;
        else if (cnt_q + CW'(1) >= CW'(LOCK_FILT))   state_d = READY;
        else                                         cnt_d   = cnt_q + CW'(1);
      end
      READY: begin
        if (!lock_s) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          state_d = RESET_HOLD;
        end else if (relock_req) begin
          state_d = RESET_HOLD;
        end else if (arm_q && cfg_req) begin
          state_d = SETTLE;
          psda_d  = cfg_psda;
          duty_d  = cfg_duty;
          fdly_d  = cfg_fdly;
          pend_d  = 1'b1;
          arm_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          state_d = RESET_HOLD;
        end else if (relock_req) begin
          state_d = RESET_HOLD;
        end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RESET_HOLD;
    endcase

    // The pending ack survives a re-reset and is issued on whichever READY entry comes next.
    if (state_d == READY && state_q != READY && pend_q) begin
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_HOLD;
      cnt_q       <= '0;
      to_q        <= '0;
      loss_q      <= 8'd0;
      tout_q      <= 1'b0;
      pend_q      <= 1'b0;
      arm_q       <= 1'b0;
      psda_q      <= PSDA_INIT;
      duty_q      <= DUTY_INIT;
      fdly_q      <= FDLY_INIT;
      pll_reset_q <= 1'b1;
      clk_ready_q <= 1'b0;
      cfg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      loss_q      <= loss_d;
      tout_q      <= tout_d;
      pend_q      <= pend_d;
      arm_q       <= arm_d;
      psda_q      <= psda_d;
      duty_q      <= duty_d;
      fdly_q      <= fdly_d;
      pll_reset_q <= (state_d == RESET_HOLD);
      clk_ready_q <= (state_d == READY);
      cfg_ack_q   <= ack_d;
    end
  end

  assign pll_reset     = pll_reset_q;
  assign psda          = psda_q;
  assign dutyda        = duty_q;
  assign fdly          = fdly_q;
  assign cfg_ack       = cfg_ack_q;
  assign cfg_busy      = (state_q != READY);
  assign clk_ready     = clk_ready_q;
  assign lock_loss_cnt = loss_q;
  assign timeout_err   = tout_q;

endmodule

// File: tb/tb_lvds_pll_ctrl.sv
// tb/tb_lvds_pll_ctrl.sv - directed self-checking bench for lvds_pll_ctrl
module tb_lvds_pll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_reset;
  logic       pll_lock;
  logic [3:0] psda, dutyda, fdly;
  logic       cfg_req;
  logic [3:0] cfg_psda, cfg_duty, cfg_fdly;
  logic       cfg_ack, cfg_busy;
  logic       relock_req;
  logic       clk_ready;
  logic [7:0] lock_loss_cnt;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;
  int exp_loss = 0;

  // Scoreboard of requested settings {psda, duty, fdly}, popped on each cfg_ack.
  logic [11:0] sb[$];

  lvds_pll_ctrl #(
    .RST_CYCLES    (16),
    .LOCK_FILT     (8),
    .SETTLE_CYCLES (64),
    .LOCK_TIMEOUT  (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_reset     (pll_reset),
    .pll_lock      (pll_lock),
    .psda          (psda),
    .dutyda        (dutyda),
    .fdly          (fdly),
    .cfg_req       (cfg_req),
    .cfg_psda      (cfg_psda),
    .cfg_duty      (cfg_duty),
    .cfg_fdly      (cfg_fdly),
    .cfg_ack       (cfg_ack),
    .cfg_busy      (cfg_busy),
    .relock_req    (relock_req),
    .clk_ready     (clk_ready),
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_reset(input string tag, input int max);
    int n = 0;
    while (pll_reset !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(pll_reset), 1);
  endtask

  task automatic wait_ready(input string tag, input int max);
    int n = 0;
    while (clk_ready !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(clk_ready), 1);
  endtask

  task automatic check_ack_data();
    logic [11:0] e;
    chk("sb_has_entry", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ack_psda", 32'(psda), 32'(e[11:8]));
      chk("ack_duty", 32'(dutyda), 32'(e[7:4]));
      chk("ack_fdly", 32'(fdly), 32'(e[3:0]));
    end
  endtask

  initial begin
    int n;
    int early;
    int acks;

    rst_n = 1'b0; pll_lock = 1'b0; relock_req = 1'b0;
    cfg_req = 1'b0; cfg_psda = 4'h0; cfg_duty = 4'h0; cfg_fdly = 4'h0;
    tick(3);

    chk("rst_pll_reset", 32'(pll_reset), 1);
    chk("rst_psda", 32'(psda), 0);
    chk("rst_duty", 32'(dutyda), 32'h8);
    chk("rst_fdly", 32'(fdly), 0);
    chk("rst_clk_ready", 32'(clk_ready), 0);
    chk("rst_cfg_ack", 32'(cfg_ack), 0);
    chk("rst_cfg_busy", 32'(cfg_busy), 1);
    chk("rst_loss", 32'(lock_loss_cnt), 0);
    chk("rst_timeout", 32'(timeout_err), 0);

    // Power-up: pll_reset high through cycle 15, lock rises 40 cycles after release.
    rst_n = 1'b1;
    chk("pu_reset_c0", 32'(pll_reset), 1);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("pu_reset_hold", 32'(pll_reset), 1);
    end
    tick();
    chk("pu_reset_c16", 32'(pll_reset), 0);
    chk("pu_busy", 32'(cfg_busy), 1);
    tick(24);
    chk("pu_not_ready_40", 32'(clk_ready), 0);
    pll_lock = 1'b1;
    tick(9);
    chk("pu_not_ready_49", 32'(clk_ready), 0);
    chk("pu_busy_49", 32'(cfg_busy), 1);
    tick();
    chk("pu_ready_50", 32'(clk_ready), 1);
    chk("pu_busy_50", 32'(cfg_busy), 0);

    // Lock glitch in FILTER, entered through a relock request.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("rl1_pll_reset", 32'(pll_reset), 1);
    chk("rl1_clk_ready", 32'(clk_ready), 0);
    chk("rl1_loss", 32'(lock_loss_cnt), 0);
    pll_lock = 1'b0;
    tick(16);
    chk("gl_wait_lock", 32'(pll_reset), 0);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("gl_not_ready", 32'(clk_ready), 0);
    end
    tick();
    chk("gl_ready", 32'(clk_ready), 1);
    chk("gl_pll_reset", 32'(pll_reset), 0);

    // Configuration change and held request.
    cfg_req = 1'b1; cfg_psda = 4'h5; cfg_duty = 4'h9; cfg_fdly = 4'h3;
    sb.push_back({4'h5, 4'h9, 4'h3});
    tick();
    chk("cfg_psda_next", 32'(psda), 5);
    chk("cfg_duty_next", 32'(dutyda), 9);
    chk("cfg_fdly_next", 32'(fdly), 3);
    chk("cfg_ready_drop", 32'(clk_ready), 0);
    chk("cfg_busy_set", 32'(cfg_busy), 1);
    n = 0; early = 0;
    while (cfg_ack !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (clk_ready === 1'b1 && cfg_ack !== 1'b1) early++;
    end
    chk("settle_len", n, 64);
    chk("settle_ready_early", early, 0);
    chk("ack_with_ready", 32'(clk_ready), 1);
    check_ack_data();
    cfg_psda = 4'hA;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cfg_ack === 1'b1) acks++;
    end
    chk("held_req_acks", acks, 0);
    chk("held_req_psda", 32'(psda), 5);
    chk("held_req_ready", 32'(clk_ready), 1);
    cfg_req = 1'b0;
    tick();

    // Lock loss during SETTLE keeps settings and the pending ack.
    cfg_req = 1'b1; cfg_psda = 4'h5; cfg_duty = 4'h6; cfg_fdly = 4'h2;
    sb.push_back({4'h5, 4'h6, 4'h2});
    tick();
    chk("cfg2_duty", 32'(dutyda), 6);
    tick(30);
    pll_lock = 1'b0;
    wait_reset("ls_reset", 10);
    exp_loss = 1;
    chk("ls_loss", 32'(lock_loss_cnt), exp_loss);
    chk("ls_psda", 32'(psda), 5);
    pll_lock = 1'b1;
    n = 0;
    while (cfg_ack !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("ls_ack_seen", 32'(cfg_ack), 1);
    check_ack_data();
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cfg_ack === 1'b1) acks++;
    end
    chk("ls_single_ack", acks, 0);
    cfg_req = 1'b0;
    tick();

    // Timeout with lock held low.
    pll_lock = 1'b0;
    wait_reset("to_drop", 10);
    exp_loss = 2;
    chk("to_loss", 32'(lock_loss_cnt), exp_loss);
    tick(115);
    chk("to_before", 32'(timeout_err), 0);
    chk("to_before_rst", 32'(pll_reset), 0);
    tick();
    chk("to_set", 32'(timeout_err), 1);
    chk("to_rereset", 32'(pll_reset), 1);
    pll_lock = 1'b1;
    wait_ready("to_relock", 100);
    chk("to_sticky", 32'(timeout_err), 1);
    chk("to_loss_same", 32'(lock_loss_cnt), exp_loss);

    // Saturation over 300 lock losses.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      wait_reset("sat_drop", 10);
      pll_lock = 1'b1;
      if (exp_loss < 255) exp_loss++;
      wait_ready("sat_up", 60);
    end
    chk("sat_loss", 32'(lock_loss_cnt), exp_loss);
    chk("sat_255", 32'(lock_loss_cnt), 255);

    // Relock request after saturation.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("rl2_pll_reset", 32'(pll_reset), 1);
    chk("rl2_clk_ready", 32'(clk_ready), 0);
    wait_ready("rl2_up", 60);
    chk("rl2_loss", 32'(lock_loss_cnt), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
